// File: rtl/junction_sequencer.sv
// Junction manoeuvre sequencer: wait for tone direction, creep to centre, turn, brake, hand back.
// Optional per-phase watchdog with sticky FAULT state when JUNCTION_WATCHDOG_EN is defined.
module junction_sequencer #(
  parameter int CREEP_PULSES   = 40,
  parameter int TURN_PULSES    = 60,
  parameter int BRAKE_CYCLES   = 5_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tdEn,
  input  logic [1:0] tdDir,
  input  logic       shaftPulseL,
  input  logic       shaftPulseR,
  input  logic       colDetect,
  input  logic       pwmIn,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic [3:0] hbIn,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > BRAKE_CYCLES) ? TIMEOUT_CYCLES : BRAKE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [3:0] HB_OFF    = 4'b0000;
  localparam logic [3:0] HB_FWD    = 4'b0110;
  localparam logic [3:0] HB_SPIN_L = 4'b1010;
  localparam logic [3:0] HB_SPIN_R = 4'b0101;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;

  localparam logic [CNT_W-1:0] CREEP_TH = CNT_W'(CREEP_PULSES);
  localparam logic [CNT_W-1:0] TURN_TH  = CNT_W'(TURN_PULSES);
  localparam logic [CNT_W-1:0] BACK_TH  = CNT_W'(2 * TURN_PULSES);
  localparam logic [TMR_W-1:0] BRAKE_LAST = TMR_W'(BRAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DIR,
    S_CREEP,
    S_TURN,
`ifdef JUNCTION_WATCHDOG_EN
    S_BRAKE,
    S_FAULT
`else
    S_BRAKE
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       dirReg;
  logic [CNT_W-1:0] cntL, cntR;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       syn_l, syn_r;
  logic             rise_l, rise_r;
  logic             moving, paused, turn_met, phase_entry, tmr_run;
  logic [3:0]       hb_in_nxt;
  logic             en_nxt;

  // Two sync flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      syn_l <= '0;
      syn_r <= '0;
    end else begin
      syn_l <= {syn_l[1:0], shaftPulseL};
      syn_r <= {syn_r[1:0], shaftPulseR};
    end
  end

  assign rise_l = syn_l[1] & ~syn_l[2];
  assign rise_r = syn_r[1] & ~syn_r[2];

  assign moving = (state == S_CREEP) || (state == S_TURN);
  assign paused = moving && !colDetect;

  always_comb begin
    turn_met = 1'b1;
    case (dirReg)
      DIR_LEFT:  turn_met = (cntR >= TURN_TH);
      DIR_RIGHT: turn_met = (cntL >= TURN_TH);
      default:   turn_met = (cntL >= BACK_TH);
    endcase
  end

  // Phase exits are evaluated before the pause and the watchdog, so an exit always wins.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_WAIT_DIR;
      S_WAIT_DIR: if (tdEn) state_nxt = S_CREEP;
      S_CREEP:
        if (cntL >= CREEP_TH && cntR >= CREEP_TH)
          state_nxt = (dirReg == DIR_STRAIGHT) ? S_BRAKE : S_TURN;
      S_TURN:     if (turn_met) state_nxt = S_BRAKE;
      S_BRAKE:    if (tmr == BRAKE_LAST) state_nxt = S_IDLE;
`ifdef JUNCTION_WATCHDOG_EN
      S_FAULT:    state_nxt = S_FAULT;
`endif
      default:    state_nxt = S_IDLE;
    endcase
`ifdef JUNCTION_WATCHDOG_EN
    if (state_nxt == state && (state == S_WAIT_DIR || moving) && !paused &&
        tmr == TMR_W'(TIMEOUT_CYCLES - 1))
      state_nxt = S_FAULT;
`endif
  end

  assign phase_entry = (state_nxt != state);

  always_comb begin
    tmr_run = (state == S_BRAKE);
`ifdef JUNCTION_WATCHDOG_EN
    if ((state == S_WAIT_DIR) || (moving && colDetect)) tmr_run = 1'b1;
`endif
  end

  always_comb begin
    hb_in_nxt = HB_OFF;
    case (state_nxt)
      S_CREEP: hb_in_nxt = HB_FWD;
      S_TURN:  hb_in_nxt = (dirReg == DIR_LEFT) ? HB_SPIN_L : HB_SPIN_R;
      default: hb_in_nxt = HB_OFF;
    endcase
  end

  assign en_nxt = pwmIn && colDetect && (state_nxt == S_CREEP || state_nxt == S_TURN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dirReg <= 2'b00;
      cntL   <= '0;
      cntR   <= '0;
      tmr    <= '0;
      hbEnA  <= 1'b0;
      hbEnB  <= 1'b0;
      hbIn   <= HB_OFF;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT_DIR && tdEn) dirReg <= tdDir;
      if (phase_entry) begin
        cntL <= '0;
        cntR <= '0;
        tmr  <= '0;
      end else begin
        if (rise_l && cntL != '1) cntL <= cntL + CNT_W'(1);
        if (rise_r && cntR != '1) cntR <= cntR + CNT_W'(1);
        if (tmr_run) tmr <= tmr + TMR_W'(1);
      end
      hbEnA <= en_nxt;
      hbEnB <= en_nxt;
      hbIn  <= hb_in_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state == S_BRAKE) && (state_nxt == S_IDLE);
    end
  end

`ifdef JUNCTION_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) fault <= 1'b0;
    else     fault <= (state_nxt == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule
